// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input conditioning blocks: debounce FSM state encoding.
package input_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } db_state_e;

endpackage

// File: rtl/input_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces one raw asynchronous input: synchronizer, stability-count FSM,
// registered rise/fall pulses and a saturating count of accepted rising events.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = 10,
  parameter int unsigned EVT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clr_count,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic [EVT_W-1:0] evt_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [EVT_W-1:0] EVT_ONE  = EVT_W'(1);

  logic din_sync;

  sync_2ff u_sync_din (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_sync)
  );

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [EVT_W-1:0] evt_q, evt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      evt_q   <= evt_d;
    end
  end

  // The counter holds the number of consecutive cycles the new level has been seen.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        cnt_d = '0;
        if (din_sync) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!din_sync) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        cnt_d = '0;
        if (!din_sync) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (din_sync) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // Counts on the registered rise pulse; a clear in that same cycle drops the event.
  always_comb begin
    evt_d = evt_q;
    if (clr_count) begin
      evt_d = '0;
    end else if (rise_q && (evt_q != '1)) begin
      evt_d = evt_q + EVT_ONE;
    end
  end

  assign dout      = dout_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign evt_count = evt_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DEBOUNCE_CYCLES=4, EVT_W=3.
module tb_input_debouncer;

  logic       clk;
  logic       rst;
  logic       din;
  logic       clr_count;
  logic       dout;
  logic       rise;
  logic       fall;
  logic [2:0] evt_count;

  int tests;
  int fails;

  input_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3),
    .EVT_W           (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .clr_count (clr_count),
    .dout      (dout),
    .rise      (rise),
    .fall      (fall),
    .evt_count (evt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       din;
    logic       clr;
    logic       e_dout;
    logic       e_rise;
    logic       e_fall;
    logic [2:0] e_evt;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic d, input logic c, input logic o,
                              input logic r, input logic f, input logic [2:0] e);
    vec_t v;
    v.din = d; v.clr = c; v.e_dout = o; v.e_rise = r; v.e_fall = f; v.e_evt = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: {dout,rise,fall,evt} got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  int exp_evt;

  task automatic press();
    din = 1'b1;
    repeat (10) tick();
    din = 1'b0;
    repeat (10) tick();
    if (exp_evt < 7) exp_evt++;
    check_int("press_evt", int'(evt_count), exp_evt);
  endtask

  initial begin
    int   rises;
    int   falls;
    logic found;

    tests = 0;
    fails = 0;
    rst = 1'b1;
    din = 1'b0;
    clr_count = 1'b0;

    // Table: clean press then clean release, then an idle clear.
    for (int i = 0; i < 5; i++)  vecs[i] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    vecs[5] = mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    vecs[6] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
    vecs[7] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
    for (int i = 8; i < 13; i++) vecs[i] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
    vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    vecs[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Reset held while din toggles.
    #2;
    check("reset_t0", {dout, rise, fall, evt_count}, 6'b0);
    for (int i = 0; i < 8; i++) begin
      din = i[0];
      tick();
      check("reset_hold", {dout, rise, fall, evt_count}, 6'b0);
    end
    din = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 17; i++) begin
      din       = vecs[i].din;
      clr_count = vecs[i].clr;
      tick();
      check($sformatf("vec%0d", i), {dout, rise, fall, evt_count},
            {vecs[i].e_dout, vecs[i].e_rise, vecs[i].e_fall, vecs[i].e_evt});
    end
    clr_count = 1'b0;
    exp_evt = 0;

    // Bounce: 3 high / 2 low never lasts long enough to be accepted.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        din = (c < 3);
        tick();
        check("bounce", {dout, rise, fall, evt_count}, 6'b0);
      end
    end
    din = 1'b1;
    rises = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rise) rises++;
    end
    check_int("bounce_rises", rises, 1);
    exp_evt = 1;
    check("bounce_settled", {dout, rise, fall, evt_count}, {1'b1, 1'b0, 1'b0, 3'd1});

    // Release from dout=1.
    din = 1'b0;
    falls = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (fall) falls++;
    end
    check_int("release_falls", falls, 1);
    check("release_settled", {dout, rise, fall, evt_count}, {1'b0, 1'b0, 1'b0, 3'd1});

    // Saturation at 7.
    for (int p = 0; p < 9; p++) press();
    check_int("sat_value", int'(evt_count), 7);

    // Clear coinciding with the rise pulse wins and drops the event.
    din = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      tick();
      if (rise) found = 1'b1;
    end
    check_int("clr_rise_seen", int'(found), 1);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check_int("clr_with_rise", int'(evt_count), 0);
    repeat (3) tick();
    check_int("clr_event_dropped", int'(evt_count), 0);
    din = 1'b0;
    repeat (10) tick();
    exp_evt = 0;

    // Async reset mid-WAIT_HI (cnt=2), then a full debounce from scratch.
    press();
    din = 1'b1;
    repeat (4) tick();
    check("pre_reset", {dout, rise, fall, evt_count}, {1'b0, 1'b0, 1'b0, 3'd1});
    rst = 1'b1;
    #1;
    check("async_reset", {dout, rise, fall, evt_count}, 6'b0);
    repeat (2) tick();
    check("reset_held", {dout, rise, fall, evt_count}, 6'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("restart_e%0d", e), {dout, rise, fall, evt_count},
            {logic'(e >= 6), logic'(e == 6), 1'b0, (e >= 7) ? 3'd1 : 3'd0});
    end
    din = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
